// File: rtl/if_fetch_stage_pkg.sv
// Shared fetch-stage types: state encoding, PC mux select, 32-bit word and default PC constants.
// Combinational only; HALT exists only when IF_ALIGN_CHECK_EN is defined.
package if_fetch_stage_pkg;

  typedef logic [31:0] word_t;

  localparam word_t RESET_PC = 32'h0000_0000;
  localparam word_t PC_STEP  = 32'd4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    BUF   = 3'd2,
    DRAIN = 3'd3
`ifdef IF_ALIGN_CHECK_EN
    ,
    HALT  = 3'd4
`endif
  } state_e;

  typedef enum logic [1:0] {
    PC_HOLD     = 2'd0,
    PC_SEQ      = 2'd1,
    PC_REDIRECT = 2'd2
  } pc_sel_e;

  function automatic word_t align_pc(input word_t a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory req/ack port; the fetch stage is master, the memory is slave.
// req/addr hold steady from request until the ack cycle.
interface if_fetch_stage_if;
  import if_fetch_stage_pkg::*;

  logic  imem_req;
  word_t imem_addr;
  logic  imem_ack;
  word_t imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/if_pc_reg.sv
// Program counter with hold / sequential / redirect next-PC mux.
// One-cycle update; the caller owns all stall and priority decisions through sel.
module if_pc_reg
  import if_fetch_stage_pkg::*;
#(
  parameter word_t RESET_PC = if_fetch_stage_pkg::RESET_PC,
  parameter word_t PC_STEP  = if_fetch_stage_pkg::PC_STEP
) (
  input  logic    clk,
  input  logic    rst,
  input  pc_sel_e sel,
  input  word_t   target,
  output word_t   pc
);

  word_t pc_q;
  word_t pc_d;

  // 32-bit add wraps naturally: 32'hFFFF_FFFC + 4 -> 0.
  always_comb begin
    pc_d = pc_q;
    case (sel)
      PC_SEQ:      pc_d = pc_q + PC_STEP;
      PC_REDIRECT: pc_d = target;
      default:     pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Fetch stage: owns the PC, drives imem req/ack, registers {pc, instr, valid}; output one cycle after ack, frozen by pause.
// IF_ALIGN_CHECK_EN adds if_misalign: a misaligned redirect target halts fetching until reset.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter word_t RESET_PC = if_fetch_stage_pkg::RESET_PC,
  parameter word_t PC_STEP  = if_fetch_stage_pkg::PC_STEP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pause,
  input  logic             redirect,
  input  word_t            redirect_pc,
  if_fetch_stage_if.master imem,
  output word_t            p_out,
  output word_t            i_out,
  output logic             if_valid
`ifdef IF_ALIGN_CHECK_EN
  ,
  output logic             if_misalign
`endif
);

  state_e  state_q, state_d;
  pc_sel_e pc_sel;
  word_t   pc_q;
  word_t   pc_tgt;

  word_t   p_out_q, p_out_d;
  word_t   i_out_q, i_out_d;
  logic    vld_q, vld_d;

  word_t   buf_pc_q, buf_pc_d;
  word_t   buf_instr_q, buf_instr_d;
  word_t   drain_addr_q, drain_addr_d;

  logic    req;
  word_t   addr;
  logic    redirect_en;
  state_e  drain_exit;
  state_e  redir_exit;

`ifdef IF_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;
  logic tgt_bad;

  assign tgt_bad     = (redirect_pc[1:0] != 2'b00);
  assign pc_tgt      = redirect_pc;
  assign redirect_en = redirect && (state_q != HALT);
  assign drain_exit  = misalign_q ? HALT : FETCH;
  assign redir_exit  = (tgt_bad || misalign_q) ? HALT : FETCH;
  assign misalign_d  = misalign_q | (redirect_en & tgt_bad);
  assign if_misalign = misalign_q;
`else
  assign pc_tgt      = align_pc(redirect_pc);
  assign redirect_en = redirect;
  assign drain_exit  = FETCH;
  assign redir_exit  = FETCH;
`endif

  if_pc_reg #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_reg (
    .clk    (clk),
    .rst    (rst),
    .sel    (pc_sel),
    .target (pc_tgt),
    .pc     (pc_q)
  );

  always_comb begin
    state_d      = state_q;
    pc_sel       = PC_HOLD;
    p_out_d      = p_out_q;
    i_out_d      = i_out_q;
    vld_d        = vld_q;
    buf_pc_d     = buf_pc_q;
    buf_instr_d  = buf_instr_q;
    drain_addr_d = drain_addr_q;
    req          = 1'b0;
    addr         = pc_q;

    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        req = 1'b1;
        if (imem.imem_ack) begin
          pc_sel = PC_SEQ;
          if (pause) begin
            buf_pc_d    = pc_q;
            buf_instr_d = imem.imem_rdata;
            state_d     = BUF;
          end else begin
            p_out_d = pc_q;
            i_out_d = imem.imem_rdata;
            vld_d   = 1'b1;
          end
        end else if (!pause) begin
          vld_d = 1'b0;
        end
      end
      BUF: begin
        if (!pause) begin
          p_out_d = buf_pc_q;
          i_out_d = buf_instr_q;
          vld_d   = 1'b1;
          state_d = FETCH;
        end
      end
      DRAIN: begin
        // The old request must complete before the new target may be fetched.
        req  = 1'b1;
        addr = drain_addr_q;
        if (imem.imem_ack) begin
          state_d = drain_exit;
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase

    if (redirect_en) begin
      pc_sel      = PC_REDIRECT;
      p_out_d     = p_out_q;
      i_out_d     = i_out_q;
      vld_d       = 1'b0;
      buf_pc_d    = '0;
      buf_instr_d = '0;
      if (req && !imem.imem_ack) begin
        state_d      = DRAIN;
        drain_addr_d = addr;
      end else begin
        state_d = redir_exit;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      p_out_q      <= '0;
      i_out_q      <= '0;
      vld_q        <= 1'b0;
      buf_pc_q     <= '0;
      buf_instr_q  <= '0;
      drain_addr_q <= RESET_PC;
    end else begin
      state_q      <= state_d;
      p_out_q      <= p_out_d;
      i_out_q      <= i_out_d;
      vld_q        <= vld_d;
      buf_pc_q     <= buf_pc_d;
      buf_instr_q  <= buf_instr_d;
      drain_addr_q <= drain_addr_d;
    end
  end

`ifdef IF_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end
`endif

  assign imem.imem_req  = req;
  assign imem.imem_addr = addr;
  assign p_out          = p_out_q;
  assign i_out          = i_out_q;
  assign if_valid       = vld_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed vectors for the fetch stage: per-cycle table of inputs and expected outputs,
// plus a hand-written reset-mid-wait sequence.
module tb_if_fetch_stage;
  import if_fetch_stage_pkg::*;

  logic  clk;
  logic  rst;
  logic  pause;
  logic  redirect;
  word_t redirect_pc;
  word_t p_out;
  word_t i_out;
  logic  if_valid;
`ifdef IF_ALIGN_CHECK_EN
  logic  if_misalign;
`endif

  if_fetch_stage_if mem_if();

  if_fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .pause       (pause),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (mem_if),
    .p_out       (p_out),
    .i_out       (i_out),
    .if_valid    (if_valid)
`ifdef IF_ALIGN_CHECK_EN
    ,
    .if_misalign (if_misalign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic  pause;
    logic  redir;
    word_t rpc;
    logic  ack;
    word_t rdata;
    logic  req;
    word_t addr;
    word_t p;
    word_t i;
    logic  v;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int pa, input int re, input word_t rpc, input int ack,
                              input word_t rd, input int rq, input word_t addr,
                              input word_t p, input word_t i, input int v);
    vec_t r;
    r.pause = (pa != 0);
    r.redir = (re != 0);
    r.rpc   = rpc;
    r.ack   = (ack != 0);
    r.rdata = rd;
    r.req   = (rq != 0);
    r.addr  = addr;
    r.p     = p;
    r.i     = i;
    r.v     = (v != 0);
    return r;
  endfunction

  // Each row: inputs for one cycle, and the expected req/addr plus registered outputs seen in that cycle.
  task automatic fill_vectors();
    //              pa re rpc           ack rdata        | req addr           p             i             v
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,       0, 32'h0,         32'h0,        32'h0,        0)); // IDLE
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h100,     1, 32'h0,         32'h0,        32'h0,        0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h104,     1, 32'h4,         32'h0,        32'h100,      1));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h108,     1, 32'h8,         32'h4,        32'h104,      1));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h10C,     1, 32'hC,         32'h8,        32'h108,      1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,       1, 32'h10,        32'hC,        32'h10C,      1)); // wait 1
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,       1, 32'h10,        32'hC,        32'h10C,      0)); // wait 2
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,       1, 32'h10,        32'hC,        32'h10C,      0)); // wait 3
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h110,     1, 32'h10,        32'hC,        32'h10C,      0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h114,     1, 32'h14,        32'h10,       32'h110,      1));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h118,     1, 32'h18,        32'h14,       32'h114,      1));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h11C,     1, 32'h1C,        32'h18,       32'h118,      1));
    vecs.push_back(mk(1, 0, 32'h0,        1, 32'h120,     1, 32'h20,        32'h1C,       32'h11C,      1)); // ack under pause
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,       0, 32'h0,         32'h1C,       32'h11C,      1)); // BUF
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,       0, 32'h0,         32'h1C,       32'h11C,      1)); // BUF release
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h124,     1, 32'h24,        32'h20,       32'h120,      1));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h128,     1, 32'h28,        32'h24,       32'h124,      1));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h12C,     1, 32'h2C,        32'h28,       32'h128,      1));
    vecs.push_back(mk(0, 1, 32'h400,      0, 32'h0,       1, 32'h30,        32'h2C,       32'h12C,      1)); // redirect, unacked
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,       1, 32'h30,        32'h2C,       32'h12C,      0)); // DRAIN
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h130,     1, 32'h30,        32'h2C,       32'h12C,      0)); // DRAIN ack, dropped
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h500,     1, 32'h400,       32'h2C,       32'h12C,      0));
    vecs.push_back(mk(1, 1, 32'h800,      1, 32'h504,     1, 32'h404,       32'h400,      32'h500,      1)); // redirect+pause
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h900,     1, 32'h800,       32'h400,      32'h500,      0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,       1, 32'h804,       32'h800,      32'h900,      1));
    vecs.push_back(mk(0, 1, 32'hFFFFFFFC, 1, 32'h904,     1, 32'h804,       32'h800,      32'h900,      0)); // redirect with ack
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'hAAAA,    1, 32'hFFFFFFFC,  32'h800,      32'h900,      0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'hBBBB,    1, 32'h0,         32'hFFFFFFFC, 32'hAAAA,     1)); // PC wrap
    vecs.push_back(mk(0, 1, 32'h1003,     0, 32'h0,       1, 32'h4,         32'h0,        32'hBBBB,     1)); // low bits dropped
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'hDEAD,    1, 32'h4,         32'h0,        32'hBBBB,     0));
    vecs.push_back(mk(0, 1, 32'h2000,     0, 32'h0,       1, 32'h1000,      32'h0,        32'hBBBB,     0));
    vecs.push_back(mk(0, 1, 32'h3000,     0, 32'h0,       1, 32'h1000,      32'h0,        32'hBBBB,     0)); // last redirect wins
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'hDEAD,    1, 32'h1000,      32'h0,        32'hBBBB,     0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h77,      1, 32'h3000,      32'h0,        32'hBBBB,     0));
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,       1, 32'h3004,      32'h3000,     32'h77,       1)); // pause, no ack
    vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,       1, 32'h3004,      32'h3000,     32'h77,       1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,       1, 32'h3004,      32'h3000,     32'h77,       1));
  endtask

  task automatic check_outputs(input string tag, input logic req, input word_t addr,
                               input word_t p, input word_t i, input logic v);
    check({tag, ".req"}, {31'd0, mem_if.imem_req}, {31'd0, req});
    if (req) check({tag, ".addr"}, mem_if.imem_addr, addr);
    check({tag, ".p_out"}, p_out, p);
    check({tag, ".i_out"}, i_out, i);
    check({tag, ".valid"}, {31'd0, if_valid}, {31'd0, v});
  endtask

  initial begin
    rst               = 1'b0;
    pause             = 1'b0;
    redirect          = 1'b0;
    redirect_pc       = '0;
    mem_if.imem_ack   = 1'b0;
    mem_if.imem_rdata = '0;
    fill_vectors();

    #1;
    check("reset.addr", mem_if.imem_addr, RESET_PC);
    check_outputs("reset", 1'b0, RESET_PC, 32'h0, 32'h0, 1'b0);

    @(posedge clk);
    #2 rst = 1'b1;

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      pause             = vecs[k].pause;
      redirect          = vecs[k].redir;
      redirect_pc       = vecs[k].rpc;
      mem_if.imem_ack   = vecs[k].ack;
      mem_if.imem_rdata = vecs[k].rdata;
      #1;
      check_outputs($sformatf("vec%0d", k), vecs[k].req, vecs[k].addr,
                    vecs[k].p, vecs[k].i, vecs[k].v);
    end

    // Reset in the middle of an outstanding request, with a late ack after release.
    @(negedge clk);
    pause           = 1'b0;
    redirect        = 1'b0;
    mem_if.imem_ack = 1'b0;
    rst             = 1'b0;
    #1;
    check("rst_mid.addr", mem_if.imem_addr, RESET_PC);
    check_outputs("rst_mid", 1'b0, RESET_PC, 32'h0, 32'h0, 1'b0);

    @(negedge clk);
    rst               = 1'b1;
    mem_if.imem_ack   = 1'b1;
    mem_if.imem_rdata = 32'h5555;
    #1;
    check_outputs("rst_idle", 1'b0, RESET_PC, 32'h0, 32'h0, 1'b0);

    @(negedge clk);
    mem_if.imem_rdata = 32'h100;
    #1;
    check_outputs("rst_first", 1'b1, RESET_PC, 32'h0, 32'h0, 1'b0);

    @(negedge clk);
    mem_if.imem_ack = 1'b0;
    #1;
    check_outputs("rst_deliver", 1'b1, RESET_PC + 32'd4, RESET_PC, 32'h100, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipeline, directly upstream of the IF/ID pipeline register.
- Owns the PC and drives a req/ack instruction-memory port.
- Presents {pc, instr, valid} as registered outputs feeding the IF/ID register's pc/instruction inputs.
- Honours the hazard unit's pause and redirects from branch/jump resolution.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, byte increment per sequential fetch.

Ports:
- clk  input  1  pipeline clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- pause  input  1  stall from hazard unit; freeze stage outputs and PC.
- redirect  input  1  taken branch/jump this cycle.
- redirect_pc  input  32  target PC, valid with redirect.
- imem_req  output  1  fetch request.
- imem_addr  output  32  fetch address; stable while imem_req=1 and no ack.
- imem_ack  input  1  response strobe; may be asserted in the same cycle as req (zero wait) or later.
- imem_rdata  input  32  instruction word, valid with imem_ack.
- p_out  output  32  PC of the delivered instruction.
- i_out  output  32  delivered instruction.
- if_valid  output  1  p_out/i_out hold a real instruction; 0 marks a bubble.

Behaviour:
- Reset (rst=0, async): pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=RESET_PC, p_out=0, i_out=0, if_valid=0, buffer empty, drop flag clear.
- States:
  - IDLE: one cycle after reset release, then FETCH.
  - FETCH: imem_req=1, imem_addr=pc.
  - BUF: a response is parked in the one-entry buffer while pause=1.
  - DRAIN: discarding a response that was in flight when a redirect arrived.
- Handshake rule: once imem_req rises, it and imem_addr stay constant until the cycle imem_ack=1. Never withdraw a request early, including on pause or redirect.
- FETCH, ack=1, pause=0, no redirect:
  - Next edge: p_out=pc, i_out=imem_rdata, if_valid=1, pc+=PC_STEP, stay in FETCH.
  - Throughput is 1 instr/cycle at zero wait; latency is ack cycle + 1.
- FETCH, ack=0: hold. If pause=0, if_valid drops to 0 (bubble).
- FETCH, ack=1, pause=1:
  - Store {pc, rdata} in the buffer, pc+=PC_STEP, go to BUF.
  - p_out/i_out/if_valid unchanged.
- BUF:
  - imem_req=0; outputs frozen while pause=1.
  - On pause=0: move the buffer to the outputs (if_valid=1), return to FETCH.
- pause=1 with no ack in FETCH: p_out/i_out/if_valid held. The request stays pending per the handshake rule.
- redirect=1 (priority over pause and ack):
  - pc=redirect_pc, buffer cleared, if_valid=0 at next edge (p_out/i_out retain their values but are ignored).
  - If a request is outstanding and unacked: go to DRAIN.
  - Otherwise (including ack in the same cycle): go to FETCH at the new pc and discard rdata.
- DRAIN:
  - Keep imem_req=1 at the old address until ack.
  - Discard rdata, then FETCH at redirect_pc.
  - if_valid=0 throughout.
  - A second redirect while in DRAIN overwrites pc; the last redirect wins.
- PC arithmetic: 32-bit modulo, 32'hFFFF_FFFC + 4 wraps to 0.
- Reset asserted mid-transaction: all state clears immediately. A late ack after reset release is ignored in IDLE.

Optional Feature:
- Macro: IF_ALIGN_CHECK_EN.
- With the macro: extra output if_misalign (1 bit, reset 0).
  - A redirect_pc with bits[1:0]!=0 suppresses the fetch: no imem_req.
  - The stage then goes to IDLE-like HALT, with if_valid=0 and if_misalign=1 sticky until reset.
- Without the macro: no port. Targets are used as given with low bits forced to 00.

Decomposition:
- Shared pipeline package:
  - state enum {IDLE, FETCH, BUF, DRAIN[, HALT]}.
  - Constants RESET_PC and PC_STEP.
  - 32-bit word typedef.
- One natural sub-module: if_pc_reg, holding the PC register and its next-PC mux (sequential / redirect / hold).

Test Plan:
1. Reset release, zero-wait memory returning addr+32'h100: p_out=0,4,8 on consecutive cycles, with i_out=0x100,0x104,0x108 and if_valid=1.
2. ack delayed 3 cycles at pc=0x10: imem_addr=0x10 and req held 3 cycles, if_valid=0 during the wait, then p_out=0x10.
3. pause=1 on the ack cycle for pc=0x20: outputs hold the previous instruction, req=0 in BUF. On pause release, p_out=0x20 and the next fetch is 0x24.
4. redirect to 0x400 while the request at 0x30 is unacked: req stays at 0x30 until ack, the 0x30 data never appears, and the next valid output is p_out=0x400.
5. redirect and pause asserted in the same cycle: pc=redirect_pc and if_valid=0 next cycle (redirect wins).
6. rst=0 in the middle of a wait, then release: all outputs are 0, and the first request goes to RESET_PC after the IDLE cycle.
